// File: rtl/area_mean_sequencer.sv
// Snapshots the per-area RGB sums at end of frame. Streams one 4-bit-mean colour per area,
// expanded to 8 bits per channel, to the LED driver over a valid/ready handshake.
module area_mean_sequencer #(
  parameter int NUM_AREA    = 8,
  parameter int SUM_W       = 21,
  parameter int RECIP       = 259,
  parameter int RECIP_SHIFT = 24
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [SUM_W-1:0]            SumR [NUM_AREA-1:0],
  input  logic [SUM_W-1:0]            SumG [NUM_AREA-1:0],
  input  logic [SUM_W-1:0]            SumB [NUM_AREA-1:0],
  output logic [23:0]                 led_data,
  output logic [$clog2(NUM_AREA)-1:0] led_idx,
  output logic                        led_valid,
  input  logic                        led_ready,
  output logic                        frame_done,
  output logic                        overrun,
  output logic [1:0]                  o_dbg_state
);

  localparam int IDX_W  = $clog2(NUM_AREA);
  localparam int PROD_W = SUM_W + $clog2(RECIP + 1);

  // Handshake: a beat transfers on a rising edge where led_valid & led_ready are both high;
  // led_data/led_idx are held stable from led_valid rising until that edge.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [IDX_W-1:0]   r_idx;
  logic [SUM_W-1:0]   r_snap_r [NUM_AREA-1:0];
  logic [SUM_W-1:0]   r_snap_g [NUM_AREA-1:0];
  logic [SUM_W-1:0]   r_snap_b [NUM_AREA-1:0];
  logic               w_hs;
  logic               w_last;
  logic [23:0]        w_color;

  // Mean = sum * (2^RECIP_SHIFT / pixels) >> RECIP_SHIFT, clamped to 4 bits and replicated.
  function automatic logic [7:0] to_level(input logic [SUM_W-1:0] sum);
    logic [PROD_W-1:0] prod;
    logic [PROD_W-1:0] q;
    logic [3:0]        m;
    prod = PROD_W'(sum) * PROD_W'(RECIP);
    q    = prod >> RECIP_SHIFT;
    m    = (q[PROD_W-1:4] != '0) ? 4'hF : q[3:0];
    return {m, m};
  endfunction

  assign w_hs        = led_valid & led_ready;
  assign w_last      = (r_idx == IDX_W'(NUM_AREA - 1));
  assign w_color     = {to_level(r_snap_r[r_idx]), to_level(r_snap_g[r_idx]), to_level(r_snap_b[r_idx])};
  assign o_dbg_state = r_state;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_CALC;
      S_CALC:  w_next = S_OUT;
      S_OUT:   if (w_hs) w_next = w_last ? S_IDLE : S_CALC;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      led_data   <= '0;
      led_idx    <= '0;
      led_valid  <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
      for (int i = 0; i < NUM_AREA; i++) begin
        r_snap_r[i] <= '0;
        r_snap_g[i] <= '0;
        r_snap_b[i] <= '0;
      end
    end else begin
      r_state    <= w_next;
      frame_done <= 1'b0;
      overrun    <= start && (r_state != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_idx <= '0;
            for (int i = 0; i < NUM_AREA; i++) begin
              r_snap_r[i] <= SumR[i];
              r_snap_g[i] <= SumG[i];
              r_snap_b[i] <= SumB[i];
            end
          end
        end
        S_CALC: begin
          led_data  <= w_color;
          led_idx   <= r_idx;
          led_valid <= 1'b1;
        end
        S_OUT: begin
          if (w_hs) begin
            led_valid <= 1'b0;
            if (w_last) frame_done <= 1'b1;
            else        r_idx      <= r_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_area_mean_sequencer.sv
// Directed bench for area_mean_sequencer: beats are checked against an expected queue,
// and latency, back-pressure, overrun and mid-frame reset are checked cycle by cycle.
module tb_area_mean_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        led_ready;
  logic [20:0] sum_r [7:0];
  logic [20:0] sum_g [7:0];
  logic [20:0] sum_b [7:0];
  logic [23:0] led_data;
  logic [2:0]  led_idx;
  logic        led_valid;
  logic        frame_done;
  logic        overrun;
  logic [1:0]  o_dbg_state;

  int          n_total = 0;
  int          n_bad   = 0;
  int          cyc     = 0;
  int          fd_count = 0;
  int          ov_count = 0;
  int          ov_cyc   = 0;
  int          fd_cyc_q [$];
  int          beat_cyc [$];
  logic [26:0] exp_q [$];

  area_mean_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .SumR       (sum_r),
    .SumG       (sum_g),
    .SumB       (sum_b),
    .led_data   (led_data),
    .led_idx    (led_idx),
    .led_valid  (led_valid),
    .led_ready  (led_ready),
    .frame_done (frame_done),
    .overrun    (overrun),
    .o_dbg_state(o_dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: score any handshake and pulses seen in the current cycle, then advance.
  task automatic tick();
    logic [26:0] e;
    if (led_valid && led_ready) begin
      beat_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        check("extra_beat", {5'd0, led_idx, led_data}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("beat", {5'd0, led_idx, led_data}, {5'd0, e});
      end
    end
    if (frame_done) begin
      fd_count++;
      fd_cyc_q.push_back(cyc);
    end
    if (overrun) begin
      ov_count++;
      ov_cyc = cyc;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // driver tasks
  task automatic set_all(input logic [20:0] r, input logic [20:0] g, input logic [20:0] b);
    for (int i = 0; i < 8; i++) begin
      sum_r[i] = r;
      sum_g[i] = g;
      sum_b[i] = b;
    end
  endtask

  task automatic push_frame_const(input logic [23:0] d);
    for (int i = 0; i < 8; i++) exp_q.push_back({3'(i), d});
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_fd(input string tag, input int budget);
    int n0;
    int k;
    n0 = fd_count;
    k  = 0;
    while (fd_count == n0 && k < budget) begin
      tick();
      k++;
    end
    check(tag, 32'(fd_count - n0), 32'd1);
  endtask

  task automatic check_drained(input string tag);
    check(tag, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    int          t0;
    int          k;
    int          fd0;
    int          ov0;
    logic [23:0] held;

    rst       = 1'b1;
    start     = 1'b0;
    led_ready = 1'b1;
    set_all(21'd0, 21'd0, 21'd0);
    @(posedge clk);
    #1;
    tick();
    tick();
    check("rst_valid", 32'(led_valid), 32'd0);
    check("rst_data",  32'(led_data),  32'd0);
    check("rst_idx",   32'(led_idx),   32'd0);
    check("rst_fd",    32'(frame_done), 32'd0);
    check("rst_ov",    32'(overrun),   32'd0);
    check("rst_state", 32'(o_dbg_state), 32'd0);
    rst = 1'b0;
    tick();

    // 1: uniform mean 7, latency and cadence; sums cleared after start must not matter
    beat_cyc.delete();
    fd_cyc_q.delete();
    ov0 = ov_count;
    set_all(21'd453600, 21'd453600, 21'd453600);
    push_frame_const(24'h777777);
    t0 = cyc;
    pulse_start();
    set_all(21'd0, 21'd0, 21'd0);
    wait_fd("t1_fd_seen", 40);
    check_drained("t1_drained");
    check("t1_nbeats", 32'(beat_cyc.size()), 32'd8);
    for (int i = 0; i < beat_cyc.size(); i++)
      check("t1_beat_cyc", 32'(beat_cyc[i] - t0), 32'(2 + 2 * i));
    if (fd_cyc_q.size() > 0) check("t1_fd_cyc", 32'(fd_cyc_q[0] - t0), 32'd17);
    check("t1_fd_pulse", 32'(frame_done), 32'd0);
    check("t1_no_ov", 32'(ov_count - ov0), 32'd0);
    tick();

    // 2: single lit area
    set_all(21'd0, 21'd0, 21'd0);
    sum_r[3] = 21'd972000;
    sum_b[3] = 21'd64800;
    for (int i = 0; i < 8; i++) exp_q.push_back({3'(i), (i == 3) ? 24'hFF0011 : 24'h000000});
    pulse_start();
    wait_fd("t2_fd_seen", 40);
    check_drained("t2_drained");
    tick();

    // 3: full-scale sums clamp to 15
    set_all(21'h1FFFFF, 21'h1FFFFF, 21'h1FFFFF);
    push_frame_const(24'hFFFFFF);
    pulse_start();
    wait_fd("t3_fd_seen", 40);
    check_drained("t3_drained");
    tick();

    // 4: back-pressure on idx2 with per-area distinct colours
    beat_cyc.delete();
    for (int i = 0; i < 8; i++) begin
      sum_r[i] = 21'(i * 64800);
      sum_g[i] = 21'd0;
      sum_b[i] = 21'd972000;
      exp_q.push_back({3'(i), 4'(i), 4'(i), 16'h00FF});
    end
    pulse_start();
    k = 0;
    while (!(led_valid && led_idx == 3'd2) && k < 20) begin
      tick();
      k++;
    end
    check("t4_reach_idx2", 32'(led_valid && led_idx == 3'd2), 32'd1);
    led_ready = 1'b0;
    held = led_data;
    for (int j = 0; j < 5; j++) begin
      tick();
      check("t4_hold_valid", 32'(led_valid), 32'd1);
      check("t4_hold_idx",   32'(led_idx),   32'd2);
      check("t4_hold_data",  32'(led_data),  32'(held));
    end
    led_ready = 1'b1;
    wait_fd("t4_fd_seen", 40);
    check_drained("t4_drained");
    check("t4_nbeats", 32'(beat_cyc.size()), 32'd8);
    tick();

    // 5: start mid-frame is an overrun; start on the frame_done cycle is accepted
    fd_cyc_q.delete();
    ov0 = ov_count;
    set_all(21'd453600, 21'd453600, 21'd453600);
    push_frame_const(24'h777777);
    t0 = cyc;
    pulse_start();
    set_all(21'h1FFFFF, 21'h1FFFFF, 21'h1FFFFF);
    while (cyc < t0 + 6) tick();
    pulse_start();
    set_all(21'd129600, 21'd129600, 21'd129600);
    while (cyc < t0 + 17) tick();
    push_frame_const(24'h222222);
    pulse_start();
    check("t5_fd1_count", 32'(fd_cyc_q.size()), 32'd1);
    if (fd_cyc_q.size() > 0) check("t5_fd1_cyc", 32'(fd_cyc_q[0] - t0), 32'd17);
    wait_fd("t5_fd2_seen", 40);
    check_drained("t5_drained");
    check("t5_ov_count", 32'(ov_count - ov0), 32'd1);
    check("t5_ov_cyc", 32'(ov_cyc - t0), 32'd7);
    tick();

    // 6: reset while idx3 is pending aborts the frame
    set_all(21'd453600, 21'd453600, 21'd453600);
    for (int i = 0; i < 3; i++) exp_q.push_back({3'(i), 24'h777777});
    t0 = cyc;
    pulse_start();
    while (cyc < t0 + 8) tick();
    check("t6_idx3_pending", {28'd0, led_valid, led_idx}, {28'd0, 1'b1, 3'd3});
    rst = 1'b1;
    led_ready = 1'b0;
    tick();
    rst = 1'b0;
    check("t6_valid", 32'(led_valid), 32'd0);
    check("t6_data",  32'(led_data),  32'd0);
    check("t6_state", 32'(o_dbg_state), 32'd0);
    led_ready = 1'b1;
    fd0 = fd_count;
    repeat (10) tick();
    check("t6_no_fd", 32'(fd_count - fd0), 32'd0);
    check_drained("t6_aborted_drained");
    push_frame_const(24'h777777);
    pulse_start();
    wait_fd("t6_fd_seen", 40);
    check_drained("t6_drained");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
